// File: rtl/rgb565_packer.sv
// RGB565 pixel-to-word packer for the CSI-2 transmit path.
// Packs two pixels per 32-bit payload word and reports each line's byte count.
module rgb565_packer #(
    parameter logic [15:0] PAD_PIXEL   = 16'h0000,
    parameter int          COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [15:0]            pixel,
    input  logic                   pixel_valid,
    input  logic                   pixel_last,
    output logic                   pixel_ready,
    output logic [31:0]            image_data,
    output logic                   image_data_enable,
    output logic                   image_data_last,
    output logic [3:0]             image_data_strb,
    input  logic                   image_data_ready,
    output logic [COUNT_WIDTH-1:0] line_bytes
);

    typedef enum logic {
        EMPTY,
        HALF
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [15:0]            held;
    logic [15:0]            held_next;
    logic                   load;
    logic [31:0]            word_next;
    logic [3:0]             strb_next;
    logic                   last_next;
    logic                   accept;
    logic                   transfer;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_inc;
    logic [COUNT_WIDTH:0]   count_sum;

    assign pixel_ready = !image_data_enable || image_data_ready;
    assign accept      = pixel_valid && pixel_ready;
    assign transfer    = image_data_enable && image_data_ready;

    // Saturating +2 so an oversized line never wraps back to a small count.
    assign count_sum = {1'b0, count} + {{(COUNT_WIDTH-1){1'b0}}, 2'd2};
    assign count_inc = count_sum[COUNT_WIDTH] ? '1 : count_sum[COUNT_WIDTH-1:0];

    always_comb begin
        state_next = state;
        held_next  = held;
        load       = 1'b0;
        word_next  = image_data;
        strb_next  = image_data_strb;
        last_next  = image_data_last;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    if (pixel_last) begin
                        load      = 1'b1;
                        word_next = {PAD_PIXEL, pixel};
                        strb_next = 4'b0011;
                        last_next = 1'b1;
                    end else begin
                        held_next  = pixel;
                        state_next = HALF;
                    end
                end
            end
            HALF: begin
                if (accept) begin
                    load       = 1'b1;
                    word_next  = {pixel, held};
                    strb_next  = 4'b1111;
                    last_next  = pixel_last;
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
            held  <= '0;
        end else begin
            state <= state_next;
            held  <= held_next;
        end
    end

    // A load may overwrite a word in the same cycle it transfers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            image_data        <= '0;
            image_data_enable <= 1'b0;
            image_data_last   <= 1'b0;
            image_data_strb   <= '0;
        end else if (load) begin
            image_data        <= word_next;
            image_data_enable <= 1'b1;
            image_data_last   <= last_next;
            image_data_strb   <= strb_next;
        end else if (transfer) begin
            image_data_enable <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count      <= '0;
            line_bytes <= '0;
        end else if (accept) begin
            if (pixel_last) begin
                line_bytes <= count_inc;
                count      <= '0;
            end else begin
                count <= count_inc;
            end
        end
    end

endmodule

// File: tb/tb_rgb565_packer.sv
// Scoreboard bench for rgb565_packer: line-level reference model,
// decoupled monitor with a decoder that re-extracts the pixel stream.
module tb_rgb565_packer;

    localparam logic [15:0] PAD = 16'h0000;
    localparam int          CW  = 16;

    logic          clock;
    logic          reset_n;
    logic [15:0]   pixel;
    logic          pixel_valid;
    logic          pixel_last;
    logic          pixel_ready;
    logic [31:0]   image_data;
    logic          image_data_enable;
    logic          image_data_last;
    logic [3:0]    image_data_strb;
    logic          image_data_ready;
    logic [CW-1:0] line_bytes;

    rgb565_packer #(
        .PAD_PIXEL  (PAD),
        .COUNT_WIDTH(CW)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .pixel            (pixel),
        .pixel_valid      (pixel_valid),
        .pixel_last       (pixel_last),
        .pixel_ready      (pixel_ready),
        .image_data       (image_data),
        .image_data_enable(image_data_enable),
        .image_data_last  (image_data_last),
        .image_data_strb  (image_data_strb),
        .image_data_ready (image_data_ready),
        .line_bytes       (line_bytes)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic [15:0] lb;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] txq[$];
    int          checks;
    int          errors;
    int          words;
    int          rdy_low;
    bit          watch;
    bit          rand_ready;
    logic [15:0] prev_lb;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a line of n pixels is n*2 bytes, paired low-first, odd tail padded.
    task automatic model_line(input logic [15:0] p[$]);
        int   n;
        int   lb;
        exp_t e;
        n  = p.size();
        lb = (n * 2 > 65535) ? 65535 : n * 2;
        for (int i = 0; i < n; i += 2) begin
            if (i + 1 < n) begin
                e.data = {p[i+1], p[i]};
                e.strb = 4'hF;
                e.last = (i + 2 == n);
            end else begin
                e.data = {PAD, p[i]};
                e.strb = 4'h3;
                e.last = 1'b1;
            end
            e.lb = 16'(lb);
            expq.push_back(e);
        end
        foreach (p[i]) txq.push_back(p[i]);
    endtask

    task automatic send_line(input logic [15:0] p[$], input int gap);
        int  t;
        bit  ok;
        model_line(p);
        foreach (p[i]) begin
            pixel_valid = 1'b0;
            pixel_last  = 1'b0;
            repeat ($urandom_range(0, gap)) begin
                @(posedge clock);
                #1;
            end
            pixel       = p[i];
            pixel_valid = 1'b1;
            pixel_last  = (i == p.size() - 1);
            t = 0;
            forever begin
                @(negedge clock);
                ok = pixel_ready;
                @(posedge clock);
                #1;
                if (ok) break;
                t++;
                if (t > 2000) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: got stalled expected accept");
                    pixel_valid = 1'b0;
                    return;
                end
            end
        end
        pixel_valid = 1'b0;
        pixel_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && image_data_enable && image_data_ready) begin
            words++;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h expected none", image_data);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("word_data", image_data, e.data);
                chk("word_strb", 32'(image_data_strb), 32'(e.strb));
                chk("word_last", 32'(image_data_last), 32'(e.last));
                if (e.last) begin
                    chk("line_bytes", 32'(line_bytes), 32'(e.lb));
                    prev_lb = e.lb;
                end else begin
                    chk("line_bytes_hold", 32'(line_bytes), 32'(prev_lb));
                end
                if (txq.size() > 0)
                    chk("decode_lo", 32'(image_data[15:0]), 32'(txq.pop_front()));
                if (image_data_strb[3:2] == 2'b11 && txq.size() > 0)
                    chk("decode_hi", 32'(image_data[31:16]), 32'(txq.pop_front()));
            end
        end
    end

    always @(negedge clock) begin
        if (watch && !pixel_ready) rdy_low++;
    end

    always @(posedge clock) begin
        if (rand_ready) begin
            #1;
            image_data_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [15:0] q[$];
        logic [15:0] a;
        logic [15:0] b;
        int          w0;
        int          t;
        checks           = 0;
        errors           = 0;
        words            = 0;
        rdy_low          = 0;
        watch            = 1'b0;
        rand_ready       = 1'b0;
        prev_lb          = '0;
        reset_n          = 1'b0;
        pixel            = '0;
        pixel_valid      = 1'b0;
        pixel_last       = 1'b0;
        image_data_ready = 1'b1;
        idle(3);
        chk("rst_enable", 32'(image_data_enable), 32'd0);
        chk("rst_data", image_data, 32'd0);
        chk("rst_strb", 32'(image_data_strb), 32'd0);
        chk("rst_last", 32'(image_data_last), 32'd0);
        chk("rst_line_bytes", 32'(line_bytes), 32'd0);
        reset_n = 1'b1;
        idle(2);

        q = {16'h1111, 16'h2222};
        send_line(q, 0);
        chk("t1_latency", 32'(image_data_enable), 32'd1);
        idle(4);

        q = {16'(($urandom)), 16'(($urandom)), 16'(($urandom))};
        send_line(q, 1);
        idle(4);

        q = {};
        for (int i = 0; i < 640; i++) q.push_back(16'($urandom));
        w0    = words;
        watch = 1'b1;
        send_line(q, 0);
        idle(4);
        watch = 1'b0;
        chk("t3_ready_const", 32'(rdy_low), 32'd0);
        chk("t3_word_count", 32'(words - w0), 32'd320);

        a = 16'hA5A5;
        b = 16'h5A5A;
        q = {a, b, 16'hC3C3, 16'h3C3C};
        image_data_ready = 1'b0;
        fork
            send_line(q, 0);
            begin
                t = 0;
                while (!image_data_enable && t < 100) begin
                    @(negedge clock);
                    t++;
                end
                repeat (5) begin
                    @(negedge clock);
                    chk("t4_ready_low", 32'(pixel_ready), 32'd0);
                    chk("t4_data_hold", image_data, {b, a});
                    chk("t4_strb_hold", 32'(image_data_strb), 32'hF);
                end
                @(posedge clock);
                #1;
                image_data_ready = 1'b1;
            end
        join
        idle(4);

        pixel       = 16'hABCD;
        pixel_valid = 1'b1;
        pixel_last  = 1'b0;
        @(posedge clock);
        #3;
        pixel_valid = 1'b0;
        reset_n     = 1'b0;
        #1;
        chk("t5_enable", 32'(image_data_enable), 32'd0);
        chk("t5_data", image_data, 32'd0);
        chk("t5_strb", 32'(image_data_strb), 32'd0);
        chk("t5_last", 32'(image_data_last), 32'd0);
        chk("t5_line_bytes", 32'(line_bytes), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        prev_lb = '0;
        q = {16'h1234, 16'h5678};
        send_line(q, 0);
        idle(4);

        rand_ready = 1'b1;
        for (int l = 0; l < 40; l++) begin
            q = {};
            for (int i = 0; i < int'($urandom_range(1, 9)); i++)
                q.push_back(16'($urandom));
            send_line(q, 3);
        end
        rand_ready = 1'b0;
        @(posedge clock);
        #2;
        image_data_ready = 1'b1;
        t = 0;
        while ((expq.size() != 0 || txq.size() != 0) && t < 1000) begin
            @(posedge clock);
            t++;
        end
        chk("drain_words", 32'(expq.size()), 32'd0);
        chk("drain_pixels", 32'(txq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
